// File: rtl/face_fetch_pkg.sv
// Shared widths, limits and FSM state encoding for the face fetch block.
package face_fetch_pkg;
  localparam int VTX_W       = 24;
  localparam int IDX_W       = 20;
  localparam int CNT_W       = 21;
  localparam int COLOR_W     = 8;
  localparam int SRAM_RD_LAT = 1;

  // Largest face count that still fits a 20-bit face address space
  localparam logic [CNT_W-1:0] MAX_FACES = CNT_W'(1) << IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    FACE,
    V1,
    V2,
    V3,
    CAP,
    OUT,
    DONE
  } state_t;
endpackage

// File: rtl/face_fetch.sv
// Walks the face list, fetches the three vertices of each face from the vertex
// SRAM and presents the assembled triangle on a valid/ready interface.
module face_fetch
  import face_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 srst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_of_faces,
  output logic [IDX_W-1:0]     address_sram_get_face,
  input  logic [IDX_W-1:0]     face_v1,
  input  logic [IDX_W-1:0]     face_v2,
  input  logic [IDX_W-1:0]     face_v3,
  output logic [IDX_W-1:0]     address_sram_get_vertice_info,
  input  logic [VTX_W-1:0]     vertice_x,
  input  logic [VTX_W-1:0]     vertice_y,
  input  logic [VTX_W-1:0]     vertice_z,
  input  logic [COLOR_W-1:0]   Color_v,
  output logic                 tri_valid,
  input  logic                 tri_ready,
  output logic [9*VTX_W-1:0]   tri_pos,
  output logic [3*COLOR_W-1:0] tri_color,
  output logic                 busy,
  output logic                 finish
);

  state_t state, next_state;

  logic [CNT_W-1:0]   face_count;
  logic [CNT_W-1:0]   face_idx;
  logic [IDX_W-1:0]   v2_idx, v3_idx;
  logic [IDX_W-1:0]   face_addr_q, vert_addr_q;
  logic [3*VTX_W-1:0] pos1, pos2, pos3;
  logic [COLOR_W-1:0] col1, col2, col3;
  logic               last_face;

  assign last_face = (face_idx == face_count - CNT_W'(1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (num_of_faces == '0) ? DONE : FACE;
      FACE: next_state = V1;
      V1:   next_state = V2;
      V2:   next_state = V3;
      V3:   next_state = CAP;
      CAP:  next_state = OUT;
      OUT:  if (tri_ready) next_state = last_face ? DONE : FACE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Addresses are driven combinationally in their fetch state so the SRAM sees
  // them that same cycle; elsewhere they repeat the last value issued.
  always_comb begin
    address_sram_get_face         = face_addr_q;
    address_sram_get_vertice_info = vert_addr_q;
    case (state)
      FACE: address_sram_get_face = face_idx[IDX_W-1:0];
      V1:   address_sram_get_vertice_info = face_v1;
      V2:   address_sram_get_vertice_info = v2_idx;
      V3:   address_sram_get_vertice_info = v3_idx;
      default: ;
    endcase
  end

  assign tri_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign finish    = (state == DONE);
  assign tri_pos   = {pos1, pos2, pos3};
  assign tri_color = {col1, col2, col3};

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state       <= IDLE;
      face_count  <= '0;
      face_idx    <= '0;
      v2_idx      <= '0;
      v3_idx      <= '0;
      face_addr_q <= '0;
      vert_addr_q <= '0;
      pos1        <= '0;
      pos2        <= '0;
      pos3        <= '0;
      col1        <= '0;
      col2        <= '0;
      col3        <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            face_count <= (num_of_faces > MAX_FACES) ? MAX_FACES : num_of_faces;
            face_idx   <= '0;
          end
        end
        FACE: face_addr_q <= face_idx[IDX_W-1:0];
        V1: begin
          v2_idx      <= face_v2;
          v3_idx      <= face_v3;
          vert_addr_q <= face_v1;
        end
        // Vertex data returns one cycle after its address, so each capture
        // lands one state after the matching address was issued.
        V2: begin
          vert_addr_q <= v2_idx;
          pos1        <= {vertice_x, vertice_y, vertice_z};
          col1        <= Color_v;
        end
        V3: begin
          vert_addr_q <= v3_idx;
          pos2        <= {vertice_x, vertice_y, vertice_z};
          col2        <= Color_v;
        end
        CAP: begin
          pos3 <= {vertice_x, vertice_y, vertice_z};
          col3 <= Color_v;
        end
        OUT: if (tri_ready && !last_face) face_idx <= face_idx + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_face_fetch.sv
// Directed bench for face_fetch: SRAM models, scoreboard of expected triangles
// and finish pulses, and a negedge monitor that checks each handshake.
module tb_face_fetch;

  logic         clk = 1'b0;
  logic         srst_n = 1'b0;
  logic         start = 1'b0;
  logic [20:0]  num_of_faces = '0;
  logic [19:0]  address_sram_get_face;
  logic [19:0]  face_v1, face_v2, face_v3;
  logic [19:0]  address_sram_get_vertice_info;
  logic [23:0]  vertice_x, vertice_y, vertice_z;
  logic [7:0]   Color_v;
  logic         tri_valid;
  logic         tri_ready = 1'b0;
  logic [215:0] tri_pos;
  logic [23:0]  tri_color;
  logic         busy;
  logic         finish;

  typedef struct {
    logic [215:0] pos;
    logic [23:0]  color;
    int           cyc;
  } tri_exp_t;

  tri_exp_t exp_q[$];
  int       fin_q[$];
  int       n_compared = 0;
  int       n_fail = 0;
  int       cyc = 0;
  logic [19:0] vaddr_q = '0;

  face_fetch dut (
    .clk                           (clk),
    .srst_n                        (srst_n),
    .start                         (start),
    .num_of_faces                  (num_of_faces),
    .address_sram_get_face         (address_sram_get_face),
    .face_v1                       (face_v1),
    .face_v2                       (face_v2),
    .face_v3                       (face_v3),
    .address_sram_get_vertice_info (address_sram_get_vertice_info),
    .vertice_x                     (vertice_x),
    .vertice_y                     (vertice_y),
    .vertice_z                     (vertice_z),
    .Color_v                       (Color_v),
    .tri_valid                     (tri_valid),
    .tri_ready                     (tri_ready),
    .tri_pos                       (tri_pos),
    .tri_color                     (tri_color),
    .busy                          (busy),
    .finish                        (finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [59:0] face_lookup(input logic [19:0] a);
    case (a)
      20'd0:   return {20'd5,  20'd9, 20'd2};
      20'd1:   return {20'd7,  20'd3, 20'd11};
      20'd2:   return {20'd1,  20'd4, 20'd8};
      20'd3:   return {20'd12, 20'd6, 20'd0};
      default: return '0;
    endcase
  endfunction

  // Vertex contents are a distinct pattern per address so swapped or stale
  // captures show up in the compared data.
  function automatic logic [23:0] vx(input logic [19:0] a); return {4'h1, a}; endfunction
  function automatic logic [23:0] vy(input logic [19:0] a); return {4'h2, a ^ 20'hFFFFF}; endfunction
  function automatic logic [23:0] vz(input logic [19:0] a); return {4'h3, a + 20'd100}; endfunction
  function automatic logic [7:0] vc(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    {face_v1, face_v2, face_v3} <= face_lookup(address_sram_get_face);
    vaddr_q <= address_sram_get_vertice_info;
  end
  assign vertice_x = vx(vaddr_q);
  assign vertice_y = vy(vaddr_q);
  assign vertice_z = vz(vaddr_q);
  assign Color_v   = vc(vaddr_q);

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushTri(input int face, input int c);
    tri_exp_t e;
    logic [19:0] a1, a2, a3;
    {a1, a2, a3} = face_lookup(20'(face));
    e.pos   = {vx(a1), vy(a1), vz(a1), vx(a2), vy(a2), vz(a2), vx(a3), vy(a3), vz(a3)};
    e.color = {vc(a1), vc(a2), vc(a3)};
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  // Pulses start for one cycle; s is the cycle in which start is presented.
  task automatic applyStimulus(input int n, output int s);
    @(posedge clk); #1;
    num_of_faces = 21'(n);
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic gotoCycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    checkOutput("idle_timeout", 256'(busy), 256'(0));
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_tri_q"}, 256'(exp_q.size()), 256'(0));
    checkOutput({tag, "_fin_q"}, 256'(fin_q.size()), 256'(0));
  endtask

  // Monitor: every handshake pops one expected triangle, every finish pops one
  // expected finish cycle.
  always @(negedge clk) begin
    if (tri_valid && tri_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_tri", 256'(exp_q.size()), 256'(1));
      end else begin
        tri_exp_t e;
        e = exp_q.pop_front();
        checkOutput("tri_pos",   256'(tri_pos),   256'(e.pos));
        checkOutput("tri_color", 256'(tri_color), 256'(e.color));
        checkOutput("tri_cycle", 256'(cyc),       256'(e.cyc));
      end
    end
    if (finish) begin
      if (fin_q.size() == 0) begin
        checkOutput("unexpected_finish", 256'(fin_q.size()), 256'(1));
      end else begin
        checkOutput("finish_cycle", 256'(cyc), 256'(fin_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tri_valid", 256'(tri_valid), 256'(0));
    checkOutput("rst_busy",      256'(busy),      256'(0));
    checkOutput("rst_finish",    256'(finish),    256'(0));
    checkOutput("rst_face_addr", 256'(address_sram_get_face), 256'(0));
    checkOutput("rst_vert_addr", 256'(address_sram_get_vertice_info), 256'(0));
    checkOutput("rst_tri_pos",   256'(tri_pos),   256'(0));
    checkOutput("rst_tri_color", 256'(tri_color), 256'(0));
    @(posedge clk); #1;
    srst_n = 1'b1;

    // Single face, address timing and latency
    $display("[TB] single face");
    tri_ready = 1'b1;
    applyStimulus(1, s);
    pushTri(0, s + 6);
    fin_q.push_back(s + 7);
    for (int k = 1; k <= 8; k++) begin
      gotoCycle(s + k);
      @(negedge clk);
      if (k == 1) checkOutput("s1_face_addr", 256'(address_sram_get_face), 256'(0));
      if (k == 2) checkOutput("s1_vaddr1", 256'(address_sram_get_vertice_info), 256'(5));
      if (k == 3) checkOutput("s1_vaddr2", 256'(address_sram_get_vertice_info), 256'(9));
      if (k == 4) checkOutput("s1_vaddr3", 256'(address_sram_get_vertice_info), 256'(2));
      checkOutput("s1_tri_valid", 256'(tri_valid), 256'(k == 6));
    end
    waitIdle(20);
    checkDrained("s1");

    // Three faces with a ten-cycle stall on face 1
    $display("[TB] stall on face 1");
    tri_ready = 1'b1;
    applyStimulus(3, s);
    pushTri(0, s + 6);
    pushTri(1, s + 22);
    pushTri(2, s + 28);
    fin_q.push_back(s + 29);
    gotoCycle(s + 7);
    tri_ready = 1'b0;
    for (int k = 12; k <= 21; k++) begin
      gotoCycle(s + k);
      @(negedge clk);
      checkOutput("s2_stall_valid", 256'(tri_valid), 256'(1));
      checkOutput("s2_stall_pos",   256'(tri_pos),   256'(exp_q[0].pos));
      checkOutput("s2_stall_color", 256'(tri_color), 256'(exp_q[0].color));
      checkOutput("s2_stall_faddr", 256'(address_sram_get_face), 256'(1));
    end
    gotoCycle(s + 22);
    tri_ready = 1'b1;
    waitIdle(40);
    checkDrained("s2");

    // Zero faces
    $display("[TB] zero faces");
    applyStimulus(0, s);
    fin_q.push_back(s + 1);
    @(negedge clk);
    checkOutput("s3_busy_1",   256'(busy),      256'(1));
    checkOutput("s3_finish_1", 256'(finish),    256'(1));
    checkOutput("s3_valid_1",  256'(tri_valid), 256'(0));
    gotoCycle(s + 2);
    @(negedge clk);
    checkOutput("s3_busy_2",   256'(busy),      256'(0));
    checkOutput("s3_valid_2",  256'(tri_valid), 256'(0));
    checkDrained("s3");

    // Start pulsed again during V2 must be ignored
    $display("[TB] start during run");
    applyStimulus(2, s);
    pushTri(0, s + 6);
    pushTri(1, s + 12);
    fin_q.push_back(s + 13);
    gotoCycle(s + 3);
    num_of_faces = 21'd7;
    start = 1'b1;
    gotoCycle(s + 4);
    start = 1'b0;
    waitIdle(30);
    gotoCycle(cyc + 3);
    checkDrained("s4");

    // Reset while a triangle is being offered
    $display("[TB] reset in OUT");
    tri_ready = 1'b0;
    applyStimulus(3, s);
    gotoCycle(s + 6);
    @(negedge clk);
    checkOutput("s5_valid_before", 256'(tri_valid), 256'(1));
    gotoCycle(s + 7);
    srst_n = 1'b0;
    gotoCycle(s + 8);
    srst_n = 1'b1;
    @(negedge clk);
    checkOutput("s5_valid_after", 256'(tri_valid), 256'(0));
    checkOutput("s5_busy_after",  256'(busy),      256'(0));
    checkOutput("s5_finish",      256'(finish),    256'(0));
    checkOutput("s5_pos_cleared", 256'(tri_pos),   256'(0));
    checkOutput("s5_vaddr_clr",   256'(address_sram_get_vertice_info), 256'(0));
    tri_ready = 1'b1;
    applyStimulus(1, s);
    pushTri(0, s + 6);
    fin_q.push_back(s + 7);
    @(negedge clk);
    checkOutput("s5_restart_faddr", 256'(address_sram_get_face), 256'(0));
    waitIdle(20);
    checkDrained("s5");

    // Four faces back to back
    $display("[TB] four faces");
    tri_ready = 1'b1;
    applyStimulus(4, s);
    for (int i = 0; i < 4; i++) pushTri(i, s + 6 + 6 * i);
    fin_q.push_back(s + 25);
    for (int i = 0; i < 4; i++) begin
      gotoCycle(s + 1 + 6 * i);
      @(negedge clk);
      checkOutput("s6_face_addr", 256'(address_sram_get_face), 256'(i));
    end
    waitIdle(40);
    checkDrained("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_fail);
    $finish;
  end

endmodule

// File: doc/face_fetch.md
FACE_FETCH -- requirements
Module: face_fetch

Interface
REQ-001 SHALL have a single clock and a synchronous, active-low reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 srst_n  in  1  synchronous active-low reset, sampled on rising clk edge.
REQ-004 start  in  1  begin traversal of the face list; sampled only in IDLE.
REQ-005 num_of_faces  in  21  face count, unsigned; latched when start is accepted.
REQ-006 address_sram_get_face  out  20  face SRAM read address.
REQ-007 face_v1 / face_v2 / face_v3  in  20 each  face SRAM read data, valid exactly 1 cycle after its address.
REQ-008 address_sram_get_vertice_info  out  20  vertex SRAM read address.
REQ-009 vertice_x / vertice_y / vertice_z  in  24 each  vertex SRAM position data, 4Q20, valid exactly 1 cycle after its address.
REQ-010 Color_v  in  8  vertex SRAM colour data, same timing as position.
REQ-011 tri_valid  out  1  assembled triangle is present on tri_pos/tri_color.
REQ-012 tri_ready  in  1  downstream vertex shader accepts the triangle.
REQ-013 tri_pos  out  216  {v1x,v1y,v1z,v2x,v2y,v2z,v3x,v3y,v3z}, with v1x in bits [215:192].
REQ-014 tri_color  out  24  {c1,c2,c3}, with c1 in bits [23:16].
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 finish  out  1  single-cycle pulse after the last triangle handshake, or after a zero-face start.

Function
REQ-017 FSM states SHALL be IDLE, FACE, V1, V2, V3, CAP, OUT, DONE.
REQ-018 IDLE: if start=1, latch num_of_faces (saturated to 1048576), clear face_idx (21 bit), and go to FACE; go to DONE instead if num_of_faces=0.
REQ-019 FACE: address_sram_get_face=face_idx[19:0]; next state V1.
REQ-020 V1: address_sram_get_vertice_info=face_v1 (direct from input); register face_v2 and face_v3; next state V2.
REQ-021 V2: vertex address = registered v2; capture vertex data as vertex 1; next state V3.
REQ-022 V3: vertex address = registered v3; capture vertex data as vertex 2; next state CAP.
REQ-023 CAP: capture vertex data as vertex 3; next state OUT.
REQ-024 OUT: tri_valid=1; tri_pos and tri_color SHALL stay constant while tri_valid=1 and tri_ready=0.
REQ-025 On a handshake (tri_valid and tri_ready both high): if face_idx = count-1, go to DONE; otherwise increment face_idx and go to FACE.
REQ-026 DONE: finish=1 for exactly one cycle; next state IDLE.
REQ-027 Latency: start accepted in cycle 0 gives the first tri_valid in cycle 6; the minimum is 6 cycles per face when tri_ready is held at 1.
REQ-028 start asserted outside IDLE SHALL be ignored, with no effect on count or state.
REQ-029 tri_ready asserted outside OUT SHALL be ignored.
REQ-030 Address outputs SHALL hold their last value in states that do not drive them; their values there are don't-care.
REQ-031 Vertex indices SHALL NOT be range-checked; they are used verbatim as addresses.
REQ-032 Arithmetic: face_idx increments only in OUT; it cannot wrap because the count saturates at 2^20.

Reset
REQ-033 srst_n=0 SHALL force state IDLE, face_idx=0, latched count=0, tri_valid=0, busy=0, finish=0, both addresses=0, tri_pos=0, tri_color=0.
REQ-034 Reset mid-operation SHALL abandon the current face with no finish pulse; tri_valid drops in the cycle after reset is sampled.

Structure
REQ-035 The shared package SHALL hold: width constants (VTX_W=24, IDX_W=20, CNT_W=21, COLOR_W=8), SRAM_RD_LAT=1, and the state enumeration.
REQ-036 The block SHALL be one FSM with a capture register bank and no sub-module.

Verification
REQ-037 Scenario: num=1, face0={5,9,2}, tri_ready=1 -> vertex addresses 5,9,2 in cycles 2,3,4; tri_valid only in cycle 6 with vertex data 5/9/2 in order; finish in cycle 7.
REQ-038 Scenario: num=3, tri_ready stuck at 0 for 10 cycles on face 1 -> tri_pos/tri_color stable and face address unchanged during the stall; 3 handshakes total; exactly 1 finish pulse.
REQ-039 Scenario: num=0, start -> finish 1 cycle later; tri_valid never asserted; busy high for 1 cycle.
REQ-040 Scenario: start pulsed during V2 of a 2-face run -> no restart; exactly 2 triangles delivered.
REQ-041 Scenario: srst_n=0 while in OUT with tri_valid=1 -> tri_valid=0 next cycle; no finish; a new start then fetches from face 0.
REQ-042 Scenario: num=4, tri_ready=1 -> handshakes in cycles 6, 12, 18, 24; face addresses 0–3; finish in cycle 25.
